// File: rtl/ldl_rr_wrr.sv
// Weighted round-robin arbiter: registered grant with valid/ready handoff,
// per-requester burst credit and lock-held multi-beat packets.
module ldl_rr_wrr #(
    parameter int REQ_WIDTH = 5,
    parameter int BIN_WIDTH = $clog2(REQ_WIDTH),
    parameter int WGT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_WIDTH-1:0]           req,
    input  logic [REQ_WIDTH*WGT_WIDTH-1:0] weight,
    input  logic                           lock,
    input  logic                           ready,
    output logic                           valid,
    output logic [REQ_WIDTH-1:0]           hot,
    output logic [BIN_WIDTH-1:0]           bin,
    output logic                           first
);

    logic [WGT_WIDTH-1:0] credit_p1;
    logic                 locked_p1;

    logic                 adv;
    logic                 lock_acc;
    logic                 req_cur;
    logic                 hit_hi;
    logic                 hit_lo;
    logic                 hit;
    logic [BIN_WIDTH-1:0] pick_hi;
    logic [BIN_WIDTH-1:0] pick_lo;
    logic [BIN_WIDTH-1:0] pick;
    logic [WGT_WIDTH-1:0] pick_credit;

    logic                 valid_nxt;
    logic [BIN_WIDTH-1:0] bin_nxt;
    logic                 first_nxt;
    logic [WGT_WIDTH-1:0] credit_nxt;
    logic                 locked_nxt;

    // Beats remaining after the first one; a zero weight behaves as one.
    function automatic logic [WGT_WIDTH-1:0] burst_credit(input logic [WGT_WIDTH-1:0] w);
        return (w == '0) ? '0 : w - WGT_WIDTH'(1);
    endfunction

    assign adv      = ~valid | ready;
    assign lock_acc = valid & ready & lock;

    always_comb begin
        req_cur = 1'b0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (bin == BIN_WIDTH'(i)) req_cur = req[i];
        end
    end

    // Two ordered passes: indices above bin first, then 0..bin, so bin is
    // checked last and no index outside the requester range can be chosen.
    always_comb begin
        hit_hi  = 1'b0;
        hit_lo  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (!hit_hi && req[i] && (BIN_WIDTH'(i) > bin)) begin
                hit_hi  = 1'b1;
                pick_hi = BIN_WIDTH'(i);
            end
            if (!hit_lo && req[i] && (BIN_WIDTH'(i) <= bin)) begin
                hit_lo  = 1'b1;
                pick_lo = BIN_WIDTH'(i);
            end
        end
        hit  = hit_hi | hit_lo;
        pick = hit_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        pick_credit = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (pick == BIN_WIDTH'(i)) pick_credit = burst_credit(weight[i*WGT_WIDTH +: WGT_WIDTH]);
        end
    end

    always_comb begin
        valid_nxt  = valid;
        bin_nxt    = bin;
        first_nxt  = first;
        credit_nxt = credit_p1;
        locked_nxt = locked_p1;
        if (adv) begin
            locked_nxt = lock_acc;
            if (lock_acc && req_cur) begin
                first_nxt = 1'b0;
            end else if (valid && (credit_p1 != '0) && req_cur) begin
                first_nxt  = 1'b0;
                credit_nxt = credit_p1 - WGT_WIDTH'(1);
            end else if (hit) begin
                valid_nxt  = 1'b1;
                bin_nxt    = pick;
                first_nxt  = 1'b1;
                credit_nxt = pick_credit;
            end else begin
                valid_nxt = 1'b0;
                first_nxt = 1'b0;
            end
        end
    end

    // Grant register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            bin       <= '0;
            first     <= 1'b0;
            credit_p1 <= '0;
            locked_p1 <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            bin       <= bin_nxt;
            first     <= first_nxt;
            credit_p1 <= credit_nxt;
            locked_p1 <= locked_nxt;
        end
    end

    assign hot = valid ? (REQ_WIDTH'(1) << bin) : '0;

    // A recorded lock always belongs to a beat that was presented as valid.
    a_lock_on_valid: assert property (@(posedge clk) disable iff (rst)
        locked_p1 |-> $past(valid));

    a_bin_range: assert property (@(posedge clk) disable iff (rst)
        int'(bin) < REQ_WIDTH);

endmodule
